// File: rtl/constant_scan_ctrl_if.sv
// Bus between the scan controller, the shared stuck-level detector with its
// channel input mux, and the status/register layer.
interface constant_scan_ctrl_if #(
    parameter int CH_NUM = 4,
    parameter int WIDTH  = 2,
    parameter int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic                      en_i;
    logic                      clr_i;
    logic [CH_NUM-1:0]         ch_mask_i;
    logic [SEL_W-1:0]          sel_o;
    logic                      det_rst_o;
    logic [WIDTH-1:0]          det_always_1_i;
    logic [WIDTH-1:0]          det_always_0_i;
    logic [CH_NUM*WIDTH-1:0]   stuck1_o;
    logic [CH_NUM*WIDTH-1:0]   stuck0_o;
    logic [CH_NUM-1:0]         valid_o;
    logic                      scan_done_o;

    // Controller side.
    modport slave (
        input  en_i, clr_i, ch_mask_i, det_always_1_i, det_always_0_i,
        output sel_o, det_rst_o, stuck1_o, stuck0_o, valid_o, scan_done_o
    );

    // Environment side: register layer, input mux and detector.
    modport master (
        output en_i, clr_i, ch_mask_i, det_always_1_i, det_always_0_i,
        input  sel_o, det_rst_o, stuck1_o, stuck0_o, valid_o, scan_done_o
    );
endinterface

// File: rtl/constant_scan_ctrl.sv
// Round-robin scan controller sharing one stuck-level detector across
// CH_NUM channels: select a channel, hold the detector in reset while the
// mux settles, observe for a fixed dwell window, then capture its flags.
module constant_scan_ctrl #(
    parameter int CH_NUM = 4,
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2,
    parameter int DWELL  = 40,
    parameter int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    constant_scan_ctrl_if.slave  bus
);
    localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_DWELL,
        ST_CAPTURE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d, sel_nxt;
    logic                    det_rst_q, det_rst_d;
    logic                    done_q, done_d;
    logic                    cap_we;
    logic [CH_NUM*WIDTH-1:0] stuck1_q, stuck0_q;
    logic [CH_NUM-1:0]       valid_q;

    // Lowest enabled channel index (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [CH_NUM-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, wrapping to the lowest one.
    function automatic logic [SEL_W-1:0] next_set(input logic [CH_NUM-1:0] m,
                                                  input logic [SEL_W-1:0]  cur);
        logic [SEL_W-1:0] r;
        r = lowest_set(m);
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = SEL_W'(i);
        end
        return r;
    endfunction

    assign sel_nxt = next_set(bus.ch_mask_i, sel_q);

    // Next-state, counter, channel select and pass-complete decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        cap_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en_i && (bus.ch_mask_i != '0)) begin
                    state_d = ST_SWITCH;
                    sel_d   = lowest_set(bus.ch_mask_i);
                    cnt_d   = CNT_W'(SETTLE - 1);
                end
            end
            ST_SWITCH: begin
                if (!bus.en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DWELL;
                    cnt_d   = CNT_W'(DWELL - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DWELL: begin
                if (!bus.en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!bus.en_i) begin
                    // Abandon the channel without writing its result.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cap_we = 1'b1;
                    if (bus.ch_mask_i == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SWITCH;
                        sel_d   = sel_nxt;
                        cnt_d   = CNT_W'(SETTLE - 1);
                        done_d  = (sel_nxt <= sel_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Detector runs only while the dwell window is open.
        det_rst_d = (state_d != ST_DWELL);
    end

    // Control registers: state, shared counter, select, detector reset, pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            det_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            det_rst_q <= det_rst_d;
            done_q    <= done_d;
        end
    end

    // Result bank: clear wins over capture; masked-out channels are wiped every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_i) begin
            stuck1_q <= '0;
            stuck0_q <= '0;
            valid_q  <= '0;
        end else begin
            if (cap_we) begin
                stuck1_q[sel_q*WIDTH +: WIDTH] <= bus.det_always_1_i;
                stuck0_q[sel_q*WIDTH +: WIDTH] <= bus.det_always_0_i;
                valid_q[sel_q]                 <= 1'b1;
            end
            for (int c = 0; c < CH_NUM; c++) begin
                if (!bus.ch_mask_i[c]) begin
                    stuck1_q[c*WIDTH +: WIDTH] <= '0;
                    stuck0_q[c*WIDTH +: WIDTH] <= '0;
                    valid_q[c]                 <= 1'b0;
                end
            end
        end
    end

    assign bus.sel_o       = sel_q;
    assign bus.det_rst_o   = det_rst_q;
    assign bus.scan_done_o = done_q;
    assign bus.stuck1_o    = stuck1_q;
    assign bus.stuck0_o    = stuck0_q;
    assign bus.valid_o     = valid_q;

endmodule
